// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the synchronous FIFO.
// Imported by fifo.sv; the FIFO_ERR_FLAGS_EN option lives in the top.
package fifo_pkg;

    localparam int FIFO_DEPTH_DEF = 128;
    localparam int FIFO_WIDTH_DEF = 32;

    // Pointers carry one extra wrap bit beyond the address width.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo.sv
// Flat single-clock FIFO with registered read data and registered full/empty flags.
// Define FIFO_ERR_FLAGS_EN to add registered o_overflow / o_underflow pulse outputs.
module fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = FIFO_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             o_full,
    output logic             o_empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic             o_overflow,
    output logic             o_underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = fifo_ptr_width(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] DEPTH_CNT = {1'b1, {(PW-1){1'b0}}};

    logic [PW-1:0]                 wr_ptr;
    logic [PW-1:0]                 rd_ptr;
    logic [PW-1:0]                 count;
    logic [PW-1:0]                 count_nxt_s;
    logic [DEPTH-1:0][WIDTH-1:0]   fifo_mem;
    logic                          wr_acc_s;
    logic                          rd_acc_s;

    // Acceptance is judged against the registered flags, so a write at full stays dropped even alongside a read.
    assign wr_acc_s = wr_en & ~o_full;
    assign rd_acc_s = rd_en & ~o_empty;

    // Next occupancy from the accepted-transfer pair.
    always_comb begin
        count_nxt_s = count;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count + PTR_ONE;
            2'b01:   count_nxt_s = count - PTR_ONE;
            default: count_nxt_s = count;
        endcase
    end

    // Storage array; deliberately not cleared by reset, only blocked from writing during it.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_acc_s) begin
            fifo_mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointers, occupancy, flags and registered read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= PTR_ZERO;
            rd_ptr  <= PTR_ZERO;
            count   <= PTR_ZERO;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
            rd_data <= {WIDTH{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= fifo_mem[rd_ptr[AW-1:0]];
            end
            count   <= count_nxt_s;
            o_full  <= (count_nxt_s == DEPTH_CNT);
            o_empty <= (count_nxt_s == PTR_ZERO);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // One-cycle pulses reporting a dropped write or an ignored read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= wr_en & o_full;
            o_underflow <= rd_en & o_empty;
        end
    end
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: hand table, fill/drain, simultaneous access and random traffic
// against a queue model. Checks o_overflow/o_underflow when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo;

    localparam int DEPTH = 128;
    localparam int WIDTH = 32;

    logic             i_clk;
    logic             i_rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             o_full;
    logic             o_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic             o_overflow;
    logic             o_underflow;
`endif

    fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .o_full  (o_full),
        .o_empty (o_empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: contents in write order plus the last word read out.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_rd;
    logic             exp_ovf;
    logic             exp_unf;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] d;
        logic        e;
        logic        f;
        logic [31:0] cnt;
        logic [31:0] rdd;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given request; model updated, outputs settled at #1 after the edge.
    task automatic cyc(input logic w, input logic r, input logic [WIDTH-1:0] d);
        int  sz;
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        sz      = q.size();
        exp_ovf = w && (sz == DEPTH);
        exp_unf = r && (sz == 0);
        @(posedge i_clk);
        #1;
        if (r && sz > 0) exp_rd = q.pop_front();
        if (w && sz < DEPTH) q.push_back(d);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_rd_data"}, rd_data, exp_rd);
        chk({tag, "_empty"}, {31'd0, o_empty}, {31'd0, q.size() == 0});
        chk({tag, "_full"}, {31'd0, o_full}, {31'd0, q.size() == DEPTH});
        chk({tag, "_count"}, 32'(dut.count), q.size());
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        q.delete();
        exp_rd = 32'd0;
    endtask

    initial begin
        i_rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 32'd0;
        exp_rd = 32'd0; exp_ovf = 1'b0; exp_unf = 1'b0;

        vecs[0] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 32'd0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 32'd1, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h22, 1'b0, 1'b0, 32'd2, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 32'd2, 32'h11};
        vecs[4] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 32'd1, 32'h22};
        vecs[5] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 32'd0, 32'h33};
        vecs[6] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 32'd0, 32'h33};
        vecs[7] = '{1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'd1, 32'h33};
        vecs[8] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 32'd0, 32'h44};

        // Reset held two cycles with requests active.
        do_reset();
        chk("rst_empty", {31'd0, o_empty}, 32'd1);
        chk("rst_full", {31'd0, o_full}, 32'd0);
        chk("rst_count", 32'(dut.count), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_wr_ptr", 32'(dut.wr_ptr), 32'd0);

        // Hand-computed vectors, including the read+write-at-empty corner.
        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].wr, vecs[i].rd, vecs[i].d);
            chk($sformatf("vec%0d_empty", i), {31'd0, o_empty}, {31'd0, vecs[i].e});
            chk($sformatf("vec%0d_full", i), {31'd0, o_full}, {31'd0, vecs[i].f});
            chk($sformatf("vec%0d_count", i), 32'(dut.count), vecs[i].cnt);
            chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].rdd);
        end

        // Fill past capacity; extra writes must be dropped.
        do_reset();
        for (int i = 0; i < DEPTH + 10; i++) begin
            cyc(1'b1, 1'b0, $urandom);
            chk_model($sformatf("fill%0d", i));
        end
        chk("fill_wr_ptr", 32'(dut.wr_ptr), 32'd128);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("fill_mem%0d", i), dut.fifo_mem[i], q[i]);
        end
`ifdef FIFO_ERR_FLAGS_EN
        cyc(1'b1, 1'b0, 32'h5A5A_5A5A);
        chk("ovf_pulse", {31'd0, o_overflow}, {31'd0, exp_ovf});
        chk("ovf_on", {31'd0, o_overflow}, 32'd1);
        cyc(1'b0, 1'b0, 32'd0);
        chk("ovf_clear", {31'd0, o_overflow}, 32'd0);
`endif

        // Drain past empty; order preserved, last word held.
        for (int i = 0; i < DEPTH + 10; i++) begin
            cyc(1'b0, 1'b1, 32'd0);
            chk_model($sformatf("drain%0d", i));
        end
`ifdef FIFO_ERR_FLAGS_EN
        chk("unf_pulse", {31'd0, o_underflow}, {31'd0, exp_unf});
        chk("unf_on", {31'd0, o_underflow}, 32'd1);
        cyc(1'b0, 1'b0, 32'd0);
        chk("unf_clear", {31'd0, o_underflow}, 32'd0);
`endif

        // Simultaneous read and write at DEPTH-1 entries.
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) cyc(1'b1, 1'b0, $urandom);
        cyc(1'b1, 1'b1, 32'hCAFE_F00D);
        chk("rw127_count", 32'(dut.count), 32'd127);
        chk("rw127_wr_ptr", 32'(dut.wr_ptr), 32'd128);
        chk("rw127_rd_ptr", 32'(dut.rd_ptr), 32'd1);
        chk("rw127_full", {31'd0, o_full}, 32'd0);
        chk_model("rw127");

        // Random traffic: 25% each, then 50% for pointer wrap-around.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            cyc($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom);
            chk_model($sformatf("rnd25_%0d", i));
        end
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(1) == 1, $urandom_range(1) == 1, $urandom);
            chk_model($sformatf("rnd50_%0d", i));
        end

        // Reset mid-transfer discards contents.
        do_reset();
        chk("midrst_empty", {31'd0, o_empty}, 32'd1);
        chk("midrst_rd_ptr", 32'(dut.rd_ptr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DEPTH, default 128, number of entries; SHALL be a power of two, at least 2.
REQ-002 Parameter WIDTH, default 32, data word width in bits.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port wr_en, input, 1 bit: write request.
REQ-006 Port wr_data, input, WIDTH bits: write data, sampled with wr_en.
REQ-007 Port rd_en, input, 1 bit: read request.
REQ-008 Port rd_data, output, WIDTH bits: registered read data.
REQ-009 Port o_full, output, 1 bit: FIFO holds DEPTH entries.
REQ-010 Port o_empty, output, 1 bit: FIFO holds zero entries.

Function
REQ-011 Internal signals SHALL be named as follows, for hierarchical probing:
- wr_ptr, rd_ptr and count, each $clog2(DEPTH)+1 bits;
- fifo_mem, a packed array [DEPTH-1:0][WIDTH-1:0].
REQ-012 A write is accepted when wr_en=1 and o_full=0 at the rising edge. On acceptance:
- fifo_mem[wr_ptr low bits] SHALL take wr_data;
- wr_ptr SHALL increment by 1 and wrap modulo 2*DEPTH.
REQ-013 A read is accepted when rd_en=1 and o_empty=0 at the rising edge. On acceptance:
- rd_data SHALL take fifo_mem[rd_ptr low bits] at that same edge, so data is valid one cycle after the request;
- rd_ptr SHALL increment and wrap modulo 2*DEPTH.
REQ-014 rd_data SHALL hold its previous value on every cycle with no accepted read.
REQ-015 count SHALL change as follows each edge:
- +1 on an accepted write alone;
- -1 on an accepted read alone;
- unchanged when both or neither are accepted.
REQ-016 Flags SHALL be registered from the next-state count:
- o_full=1 exactly when count==DEPTH;
- o_empty=1 exactly when count==0.
REQ-017 A write while o_full=1 SHALL be dropped, with no change to memory, pointers or count. This applies even when a read is accepted in the same cycle.
REQ-018 A read while o_empty=1 SHALL be ignored: rd_data and pointers stay unchanged. A simultaneous write SHALL still be accepted.
REQ-019 A simultaneous accepted read and write SHALL leave count unchanged, with both pointers advancing.
REQ-020 Data SHALL be returned in strict write order across pointer wrap-around.

Reset
REQ-021 While i_rst=1 at a rising edge, the following SHALL be forced:
- wr_ptr=0, rd_ptr=0, count=0;
- o_empty=1, o_full=0, rd_data=0.
REQ-022 Reset SHALL override wr_en and rd_en. A reset in the middle of a transfer discards all stored entries.
REQ-023 fifo_mem contents need not be cleared by reset.

Configuration
REQ-024 With FIFO_ERR_FLAGS_EN defined, two extra output ports SHALL exist:
- o_overflow, 1 bit, registered: pulses for one cycle after a write dropped under REQ-017;
- o_underflow, 1 bit, registered: pulses for one cycle after a read ignored under REQ-018;
- both reset to 0.
REQ-025 Without FIFO_ERR_FLAGS_EN, these ports and their logic SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-026 Package fifo_pkg SHALL hold:
- default constants FIFO_DEPTH_DEF=128 and FIFO_WIDTH_DEF=32;
- a function returning the pointer width $clog2(depth)+1.
REQ-027 The design SHALL be flat, with no sub-module, so that fifo_mem, wr_ptr, rd_ptr and count stay top-level signals.

Verification
REQ-028 Hold i_rst=1 for 2 cycles -> o_empty=1, o_full=0, count=0, rd_data=0.
REQ-029 Write DEPTH+10 random words with no reads -> o_full=1 after the 128th accepted write. count stays 128, and the 10 extra writes leave memory and wr_ptr unchanged.
REQ-030 From full, assert rd_en for DEPTH+10 cycles:
- words return in write order, each one cycle after its request;
- o_empty=1 after the 128th read;
- extra reads leave rd_data holding the last word.
REQ-031 Run 50 cycles of random wr_en and rd_en (each at 25%) against a reference queue -> every rd_data equals the queue's popped value and no mismatches occur.
REQ-032 With the FIFO at 127 entries, assert wr_en and rd_en together:
- count stays 127 and both pointers advance;
- repeat at empty: the write is accepted, count becomes 1, and the read is ignored.
REQ-033 With FIFO_ERR_FLAGS_EN defined:
- writing when full -> o_overflow=1 for exactly one cycle;
- reading when empty -> o_underflow=1 for exactly one cycle.
